// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit with valid/ready streaming and ALU flags.
// Lookahead groups are spread LSB-first over STAGES registers; the last register is the output.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG   = WIDTH / GROUP;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage combinational inputs (stage 0 from the ports, later stages from the pipe)
  logic [WIDTH-1:0] op_a   [STAGES];
  logic [WIDTH-1:0] op_b   [STAGES];
  logic [WIDTH-1:0] psum   [STAGES];
  logic             cin_s  [STAGES];
  logic             vld_s  [STAGES];

  // Per-stage combinational results
  logic [WIDTH-1:0] sum_d  [STAGES];
  logic             cout_d [STAGES];
  logic             cmsb_d [STAGES];

  // Inter-stage registers: operands travel with the beat so no slice is resampled
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] psum_q [STAGES];
  logic             c_q    [STAGES];
  logic             vld_q  [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             advance;

  assign advance  = out_ready | ~out_valid_q;
  assign in_ready = advance;

  // Subtract folds into the add as a + ~b + ~cin
  assign op_a[0]  = a;
  assign op_b[0]  = sub ? ~b : b;
  assign psum[0]  = '0;
  assign cin_s[0] = cin ^ sub;
  assign vld_s[0] = in_valid;

  for (genvar s = 1; s < STAGES; s++) begin : g_link
    assign op_a[s]  = a_q[s-1];
    assign op_b[s]  = b_q[s-1];
    assign psum[s]  = psum_q[s-1];
    assign cin_s[s] = c_q[s-1];
    assign vld_s[s] = vld_q[s-1];
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned G_LO = s * NG / STAGES;
    localparam int unsigned G_HI = (s + 1) * NG / STAGES;
    localparam int unsigned NGS  = G_HI - G_LO;
    localparam int unsigned SW   = NGS * GROUP;
    localparam int unsigned LO   = G_LO * GROUP;

    logic [SW-1:0]    pb;
    logic [SW-1:0]    gb;
    logic [SW-1:0]    cb;
    logic [NGS-1:0]   gg;
    logic [NGS-1:0]   pp;
    logic [NGS:0]     cg;
    logic [WIDTH-1:0] ns;
    logic             acc;
    logic             prod;

    always_comb begin
      pb   = op_a[s][LO +: SW] ^ op_b[s][LO +: SW];
      gb   = op_a[s][LO +: SW] & op_b[s][LO +: SW];
      gg   = '0;
      pp   = '1;
      cg   = '0;
      cb   = '0;
      acc  = 1'b0;
      prod = 1'b1;

      for (int unsigned j = 0; j < NGS; j++) begin
        for (int unsigned k = 0; k < GROUP; k++) begin
          gg[j] = gb[j*GROUP+k] | (pb[j*GROUP+k] & gg[j]);
          pp[j] = pp[j] & pb[j*GROUP+k];
        end
      end

      // Each group carry is an independent sum of products over G/P, no group-to-group chain
      for (int unsigned j = 0; j <= NGS; j++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int unsigned m = j; m > 0; m--) begin
          acc  = acc | (prod & gg[m-1]);
          prod = prod & pp[m-1];
        end
        cg[j] = acc | (prod & cin_s[s]);
      end

      for (int unsigned j = 0; j < NGS; j++) begin
        for (int unsigned k = 0; k < GROUP; k++) begin
          acc  = 1'b0;
          prod = 1'b1;
          for (int unsigned m = k; m > 0; m--) begin
            acc  = acc | (prod & gb[j*GROUP+m-1]);
            prod = prod & pb[j*GROUP+m-1];
          end
          cb[j*GROUP+k] = acc | (prod & cg[j]);
        end
      end

      ns            = psum[s];
      ns[LO +: SW]  = pb ^ cb;
    end

    assign sum_d[s]  = ns;
    assign cout_d[s] = cg[NGS];
    assign cmsb_d[s] = cb[SW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      for (int unsigned s = 0; s < LAST; s++) begin
        vld_q[s]  <= vld_s[s];
        a_q[s]    <= op_a[s];
        b_q[s]    <= op_b[s];
        psum_q[s] <= sum_d[s];
        c_q[s]    <= cout_d[s];
      end
      out_valid_q <= vld_s[LAST];
      // Flags only load for real beats so bubble operands never reach them
      if (vld_s[LAST]) begin
        sum_q  <= sum_d[LAST];
        cout_q <= cout_d[LAST];
        ovf_q  <= cout_d[LAST] ^ cmsb_d[LAST];
        zero_q <= ~|sum_d[LAST];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead add/subtract unit, the successor to the team's 16-bit combinational lookahead adder. It splits a WIDTH-bit operation into GROUP-bit lookahead groups spread over STAGES register stages. Operands enter over a valid/ready stream and results leave over one, with full backpressure. Result flags (carry/borrow, signed overflow, zero) are produced for the datapath ALU.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
GROUP, 4, bits per lookahead group (generate/propagate block).
STAGES, 2, pipeline register stages; 1 <= STAGES <= WIDTH/GROUP. This is also the latency in cycles.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  unit can accept an operand beat.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in for add; borrow-in for subtract.
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts the result beat.
sum  output  WIDTH  result.
cout  output  1  carry-out for add; NOT-borrow for subtract.
ovf  output  1  two's-complement signed overflow.
zero  output  1  sum == 0.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits = 0. out_valid=0, sum=0, cout=0, ovf=0, zero=0. Reset overrides any in-flight or simultaneous input. in_ready is 1 in the cycle after reset.
- Arithmetic for add: {cout,sum} = a + b + cin.
- Arithmetic for subtract: {cout,sum} = a + ~b + ~cin, which equals a - b - cin. cout=1 means no borrow.
- ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is b for add and ~b for subtract.
- zero = ~|sum.
- Lookahead structure: each GROUP computes group generate G and group propagate P. Carries within a stage resolve via lookahead, not ripple across groups.
- Partitioning: groups are split evenly over the stages, with the LSB groups first. The inter-stage carry is registered.
- Unconsumed operand slices travel with the pipeline (operand skew). A slice must not be resampled from the inputs.
- Pipeline advance: advance = out_ready || !out_valid, and in_ready = advance (global-stall pipeline).
- Accept: a beat is accepted when in_valid && in_ready. Valid bits shift one stage per advancing cycle.
- Latency: with no stall, a beat accepted at edge N produces out_valid=1 with its result after edge N+STAGES-1, i.e. visible for STAGES cycles counting the accept cycle.
- Throughput: one result per cycle under continuous in_valid and out_ready.
- Stall: when out_valid && !out_ready, all stages, sum and the flags hold unchanged and in_ready=0. No beat is lost or duplicated.
- Bubbles: if in_valid=0 on an advancing cycle, a bubble enters. out_valid stays 0 for that slot. Data outputs may hold their previous value when out_valid=0.
- Ordering: results leave strictly in acceptance order.
- Output hold: outputs change only on an advancing edge.
- Any X on a/b while in_valid=0 must not propagate to the flags of valid beats.

Test Plan:
- Reset behaviour: hold rst for 2 cycles, then release. Expect out_valid=0, sum=0, all flags 0, in_ready=1.
- Add with carry: WIDTH=16, STAGES=2, add a=0x90AF, b=0x6FAF, cin=0. Expect sum=0x005E, cout=1, ovf=0, zero=0, exactly 2 cycles after accept. Repeat with cin=1: expect sum=0x005F.
- Zero result: a=0x5555, b=0xAAAA, cin=1 (add). Expect sum=0x0000, cout=1, zero=1, ovf=0.
- Subtract and signed overflow:
  - sub: a=0x0002, b=0x0006, cin=0. Expect sum=0xFFFC, cout=0, ovf=0.
  - add: a=0x7FFF, b=0x0001. Expect sum=0x8000, ovf=1, cout=0.
  - sub: a=0x8000, b=0x0001. Expect sum=0x7FFF, ovf=1, cout=1.
- Backpressure: stream 6 back-to-back beats and hold out_ready=0 for 3 cycles mid-stream. Expect in_ready=0 during the stall, outputs held, all 6 results in order with no loss or duplication.
- Reset mid-operation: assert rst with 2 beats in flight. Expect out_valid=0 on the next cycle and neither beat ever emitted. Then rerun the add test with STAGES=1 (latency 1) and STAGES=4 (latency 4).
